pipe_hazard_ctrl: RTL and testbench

- Hazard/control sequencer for the 5-stage Y86-64 pipeline.
- Drives stall/bubble inputs of every pipeline register (F, D, E, M, W) from load-use, ret, branch-mispredict and exception conditions.
- Holds the pipeline run-state FSM (post-reset flush, run, exception drain, halt) and saturating performance counters.
- Sits beside the datapath; its hazard outputs act in the same cycle they are computed.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 37 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the Y86-64 hazard controller: icodes, register id,
// status codes and run-state encodings.
package pipe_hazard_ctrl_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic logic isExc(input logic [2:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble sequencer for the 5-stage Y86-64 pipeline with run-state FSM
// and performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  input  logic             clr_cnt_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  state_e r_state;
  logic   r_halted;

  logic w_luHaz;
  logic w_retHaz;
  logic w_misPred;
  logic w_mExc;
  logic w_wExc;
  logic w_active;

  assign w_luHaz   = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                     (E_dstM_i != RNONE) &&
                     ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign w_retHaz  = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
  assign w_misPred = (E_icode_i == IJXX) && !e_Cnd_i;
  assign w_mExc    = isExc(m_stat_i);
  assign w_wExc    = isExc(W_stat_i);
  assign w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  // Reset forces FLUSH asynchronously, so reset-time outputs are the FLUSH set.
  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_stall_o  = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        F_stall_o  = 1'b1;
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
      end
      ST_RUN, ST_DRAIN: begin
        F_stall_o  = w_luHaz | w_retHaz;
        D_stall_o  = w_luHaz;
        D_bubble_o = w_misPred | (w_retHaz & ~w_luHaz);
        E_bubble_o = w_misPred | w_luHaz;
        M_bubble_o = w_mExc | w_wExc | (r_state == ST_DRAIN);
        W_stall_o  = w_wExc;
      end
      ST_HALT: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
      end
      default: begin
        F_stall_o  = 1'b1;
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
      end
    endcase
  end

  // A write-back exception always wins over a memory-stage one: go straight to HALT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_FLUSH;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_FLUSH: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_wExc) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_mExc) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_wExc) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (!w_mExc) begin
            r_state <= ST_RUN;
          end
        end
        ST_HALT: r_halted <= 1'b1;
        default: r_state <= ST_FLUSH;
      endcase
    end
  end

  assign state_o  = r_state;
  assign halted_o = r_halted;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_cycCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (r_state == ST_RUN),
    .clr_i (clr_cnt_i),
    .cnt_o (cyc_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_luCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_active & w_luHaz),
    .clr_i (clr_cnt_i),
    .cnt_o (lu_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_retCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_active & w_retHaz & ~w_luHaz),
    .clr_i (clr_cnt_i),
    .cnt_o (ret_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_misCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_active & w_misPred),
    .clr_i (clr_cnt_i),
    .cnt_o (mis_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl, built with 4-bit
// counters so saturation is reachable quickly.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [3:0]    D_icode_i, E_icode_i, M_icode_i;
  logic [3:0]    d_srcA_i, d_srcB_i, E_dstM_i;
  logic          e_Cnd_i;
  logic [2:0]    m_stat_i, W_stat_i;
  logic          clr_cnt_i;
  logic          F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o;
  logic [1:0]    state_o;
  logic          halted_o;
  logic [CW-1:0] cyc_cnt_o, lu_cnt_o, ret_cnt_o, mis_cnt_o;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .D_icode_i  (D_icode_i),
    .E_icode_i  (E_icode_i),
    .M_icode_i  (M_icode_i),
    .d_srcA_i   (d_srcA_i),
    .d_srcB_i   (d_srcB_i),
    .E_dstM_i   (E_dstM_i),
    .e_Cnd_i    (e_Cnd_i),
    .m_stat_i   (m_stat_i),
    .W_stat_i   (W_stat_i),
    .clr_cnt_i  (clr_cnt_i),
    .F_stall_o  (F_stall_o),
    .D_stall_o  (D_stall_o),
    .D_bubble_o (D_bubble_o),
    .E_bubble_o (E_bubble_o),
    .M_bubble_o (M_bubble_o),
    .W_stall_o  (W_stall_o),
    .state_o    (state_o),
    .halted_o   (halted_o),
    .cyc_cnt_o  (cyc_cnt_o),
    .lu_cnt_o   (lu_cnt_o),
    .ret_cnt_o  (ret_cnt_o),
    .mis_cnt_o  (mis_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drives one full input vector, then lets combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] dI, input logic [3:0] eI, input logic [3:0] mI,
                               input logic [3:0] sA, input logic [3:0] sB, input logic [3:0] dM,
                               input logic cnd, input logic [2:0] mS, input logic [2:0] wS);
    D_icode_i = dI; E_icode_i = eI; M_icode_i = mI;
    d_srcA_i = sA; d_srcB_i = sB; E_dstM_i = dM;
    e_Cnd_i = cnd; m_stat_i = mS; W_stat_i = wS;
    #1;
  endtask

  task automatic idle();
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearCounters();
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
  endtask

  task automatic checkHaz(input string tag, input logic [5:0] exp);
    checkOutput(tag, {26'd0, F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o},
                {26'd0, exp});
  endtask

  initial begin
    rst_i = 1'b1;
    clr_cnt_i = 1'b0;
    idle();
    // hazard vector order: F_stall D_stall D_bubble E_bubble M_bubble W_stall
    checkHaz("reset_haz", 6'b101110);
    checkOutput("reset_state", state_o, 0);
    checkOutput("reset_halted", halted_o, 0);
    checkOutput("reset_cyc", cyc_cnt_o, 0);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("flush_state", state_o, 0);
    checkHaz("flush_haz", 6'b101110);
    tick();
    checkOutput("run_state", state_o, 1);
    checkOutput("run_cnt_all", {16'd0, cyc_cnt_o, lu_cnt_o, ret_cnt_o, mis_cnt_o}, 0);
    checkHaz("run_idle_haz", 6'b000000);

    // load-use via srcA
    clearCounters();
    applyStimulus(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 3'd1, 3'd1);
    checkHaz("lu_haz", 6'b110100);
    tick();
    tick();
    checkOutput("lu_cnt2", lu_cnt_o, 2);
    applyStimulus(4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    checkHaz("lu_rnone_haz", 6'b000000);
    tick();
    checkOutput("lu_rnone_cnt", lu_cnt_o, 2);
    applyStimulus(4'h1, 4'hB, 4'h1, 4'h2, 4'h4, 4'h4, 1'b1, 3'd1, 3'd1);
    checkHaz("lu_popq_srcB", 6'b110100);

    // ret walking down D, E, M
    idle();
    clearCounters();
    applyStimulus(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    checkHaz("ret_D", 6'b101000);
    tick();
    applyStimulus(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    checkHaz("ret_E", 6'b101000);
    tick();
    applyStimulus(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    checkHaz("ret_M", 6'b101000);
    tick();
    idle();
    checkOutput("ret_cnt3", ret_cnt_o, 3);
    applyStimulus(4'h9, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 3'd1, 3'd1);
    checkHaz("ret_lu_haz", 6'b110100);
    tick();
    checkOutput("ret_lu_retcnt", ret_cnt_o, 3);
    checkOutput("ret_lu_lucnt", lu_cnt_o, 1);

    // mispredict
    idle();
    clearCounters();
    applyStimulus(4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1);
    checkHaz("mp_haz", 6'b101100);
    tick();
    checkOutput("mp_cnt1", mis_cnt_o, 1);
    applyStimulus(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    checkHaz("mp_taken_haz", 6'b000000);
    tick();
    checkOutput("mp_taken_cnt", mis_cnt_o, 1);

    // saturation and clear priority
    idle();
    clearCounters();
    for (int i = 0; i < 20; i++) tick();
    checkOutput("cyc_sat", cyc_cnt_o, 15);
    clearCounters();
    tick();
    checkOutput("cyc_after_clr", cyc_cnt_o, 1);
    clearCounters();
    checkOutput("cyc_clr_prio", cyc_cnt_o, 0);

    // exception: RUN -> DRAIN -> HALT
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd3, 3'd1);
    checkHaz("exc_m_haz", 6'b000010);
    tick();
    checkOutput("drain_state", state_o, 2);
    checkOutput("drain_cyc", cyc_cnt_o, 1);
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd3);
    checkHaz("drain_w_haz", 6'b000011);
    tick();
    checkOutput("halt_state", state_o, 3);
    checkOutput("halt_halted", halted_o, 1);
    applyStimulus(4'h9, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b0, 3'd1, 3'd1);
    checkHaz("halt_haz", 6'b110111);
    tick();
    tick();
    tick();
    checkOutput("halt_stays", state_o, 3);
    checkOutput("halt_frozen", {16'd0, cyc_cnt_o, lu_cnt_o, ret_cnt_o, mis_cnt_o}, 32'h1000);

    // async reset mid-cycle
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("areset_state", state_o, 0);
    checkOutput("areset_halted", halted_o, 0);
    checkOutput("areset_cyc", cyc_cnt_o, 0);
    rst_i = 1'b0;
    idle();
    tick();
    checkOutput("rerun_state", state_o, 1);

    // W exception has priority over m exception from RUN
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd4, 3'd2);
    checkHaz("wexc_run_haz", 6'b000011);
    tick();
    checkOutput("run_to_halt", state_o, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
